// File: rtl/cpu_pkg.sv
// Shared definitions for the control sequencer: instruction classes,
// sequencer state encoding and fault codes.
package cpu_pkg;

    // Decoder func field classes; 100-111 are undefined and fault.
    localparam logic [2:0] FUNC_ALU    = 3'b000;
    localparam logic [2:0] FUNC_LOAD   = 3'b001;
    localparam logic [2:0] FUNC_STORE  = 3'b010;
    localparam logic [2:0] FUNC_BRANCH = 3'b011;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5,
        S_FAULT     = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        FAULT_NONE    = 2'b00,
        FAULT_ILLEGAL = 2'b01,
        FAULT_TIMEOUT = 2'b10
    } fault_e;

    // Only the low half of the func space is defined.
    function automatic logic func_legal(input logic [2:0] f);
        return (f[2] == 1'b0);
    endfunction

    // Loads and stores are the only classes that visit MEM.
    function automatic logic func_is_mem(input logic [2:0] f);
        return (f == FUNC_LOAD) || (f == FUNC_STORE);
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Memory handshake watchdog. Counts unacknowledged wait cycles; expired
// flags the cycle in which the number of unacknowledged cycles, including
// the current one, reaches LIMIT.
module wait_timer #(
    parameter logic [7:0] LIMIT = 8'd255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count;

    // Count waiting cycles; clear takes priority so every wait starts at zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    // Only meaningful while a wait is in progress (enable high, no ack).
    assign expired = enable && (count == (LIMIT - 8'd1));

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer for the simple CPU core.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   FETCH     | imem_req high, wait for instruction word
//   DECODE    | dec_en high, classify func, catch halt / illegal
//   EXECUTE   | alu_en high, capture branch condition
//   MEM       | dmem_req high (dmem_we for store), wait for data ack
//   WRITEBACK | pc_en once, rf_we for ALU/load, retire instruction
//   HALT      | absorbing, halted high
//   FAULT     | absorbing, fault high, fault_code holds the cause
//
// All outputs except ir_load are decoded from registered state.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter logic [7:0] WAIT_LIMIT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    input  logic        halt,
    input  logic [2:0]  func,
    input  logic        cond_flag,
    output logic        imem_req,
    output logic        ir_load,
    output logic        dec_en,
    output logic        alu_en,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        rf_we,
    output logic        pc_en,
    output logic        st_flag,
    output logic        halted,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [31:0] instr_count
);

    localparam logic [2:0] ST_FETCH     = S_FETCH;
    localparam logic [2:0] ST_DECODE    = S_DECODE;
    localparam logic [2:0] ST_EXECUTE   = S_EXECUTE;
    localparam logic [2:0] ST_MEM       = S_MEM;
    localparam logic [2:0] ST_WRITEBACK = S_WRITEBACK;
    localparam logic [2:0] ST_HALT      = S_HALT;
    localparam logic [2:0] ST_FAULT     = S_FAULT;

    logic [2:0] state;
    logic [2:0] state_next;
    logic [2:0] func_q;
    logic       branch_q;

    logic in_fetch;
    logic in_mem;
    logic wait_active;
    logic wait_ack;
    logic timer_clear;
    logic timer_enable;
    logic timer_expired;
    logic decode_illegal;
    logic wait_timeout;

    assign in_fetch    = (state == ST_FETCH);
    assign in_mem      = (state == ST_MEM);
    assign wait_active = in_fetch || in_mem;

    // Acks are only honoured by the state that is waiting for them.
    assign wait_ack    = (in_fetch && imem_ack) || (in_mem && dmem_ack);

    // Clearing whenever no wait is pending guarantees a zero count on
    // entry to FETCH or MEM; an ack in the limit cycle suppresses expiry.
    assign timer_clear  = !wait_active || wait_ack;
    assign timer_enable = wait_active && !wait_ack;

    wait_timer #(
        .LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    assign decode_illegal = (state == ST_DECODE) && !halt && !func_legal(func);
    assign wait_timeout   = timer_expired;

    // Next-state selection; halt outranks the illegal-func check in DECODE.
    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH: begin
                if (imem_ack) begin
                    state_next = ST_DECODE;
                end else if (timer_expired) begin
                    state_next = ST_FAULT;
                end
            end
            ST_DECODE: begin
                if (halt) begin
                    state_next = ST_HALT;
                end else if (!func_legal(func)) begin
                    state_next = ST_FAULT;
                end else begin
                    state_next = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (func_is_mem(func_q)) begin
                    state_next = ST_MEM;
                end else begin
                    state_next = ST_WRITEBACK;
                end
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    state_next = ST_WRITEBACK;
                end else if (timer_expired) begin
                    state_next = ST_FAULT;
                end
            end
            ST_WRITEBACK: state_next = ST_FETCH;
            ST_HALT:      state_next = ST_HALT;
            ST_FAULT:     state_next = ST_FAULT;
            default:      state_next = ST_FAULT;
        endcase
    end

    // State register; reset returns to FETCH regardless of pending acks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Capture func in DECODE and the branch outcome in EXECUTE so that
    // later states can drive their outputs from registers only.
    always_ff @(posedge clk) begin
        if (rst) begin
            func_q   <= FUNC_ALU;
            branch_q <= 1'b0;
        end else begin
            if (state == ST_DECODE) begin
                func_q <= func;
            end
            if (state == ST_EXECUTE) begin
                branch_q <= (func_q == FUNC_BRANCH) && cond_flag;
            end
        end
    end

    // Record the fault cause on the transition into FAULT; it then holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_code <= FAULT_NONE;
        end else if (decode_illegal) begin
            fault_code <= FAULT_ILLEGAL;
        end else if (wait_timeout) begin
            fault_code <= FAULT_TIMEOUT;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_count <= 32'd0;
        end else if (state == ST_WRITEBACK) begin
            instr_count <= instr_count + 32'd1;
        end
    end

    assign imem_req = in_fetch;
    assign ir_load  = in_fetch && imem_ack;
    assign dec_en   = (state == ST_DECODE);
    assign alu_en   = (state == ST_EXECUTE);
    assign dmem_req = in_mem;
    assign dmem_we  = in_mem && (func_q == FUNC_STORE);
    assign pc_en    = (state == ST_WRITEBACK);
    assign rf_we    = (state == ST_WRITEBACK) &&
                      ((func_q == FUNC_ALU) || (func_q == FUNC_LOAD));
    assign st_flag  = (state == ST_WRITEBACK) && (func_q == FUNC_BRANCH) && branch_q;
    assign halted   = (state == ST_HALT);
    assign fault    = (state == ST_FAULT);

endmodule
